// File: rtl/dist_pkg.sv
// -----------------------------------------------------------------------------
// dist_pkg
// Shared constants for the distribution-register hazard tracking logic.
//   DREG_ADDR_W   : width of a distribution register address
//   DREG_NUM      : number of distribution registers
//   DREG_ZERO     : the hard-wired register that never carries a hazard
//   DIST_SB_DEPTH : default number of outstanding multi-cycle writes
// -----------------------------------------------------------------------------
package dist_pkg;

    localparam int               DREG_ADDR_W   = 5;
    localparam int               DREG_NUM      = 32;
    localparam logic [4:0]       DREG_ZERO     = 5'd0;
    localparam int               DIST_SB_DEPTH = 4;

endpackage : dist_pkg

// File: rtl/dist_sb_fifo.sv
// -----------------------------------------------------------------------------
// dist_sb_fifo
// Synchronous in-order FIFO holding the destinations of distribution ops that
// are in flight in the multi-cycle unit. The head is the oldest entry, which is
// the only one allowed to complete.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear of all entries (priority over push/pop)
//   push        : write push_data at the tail (caller guarantees not full)
//   push_data   : destination register address to enqueue
//   pop         : drop the head entry (caller guarantees not empty)
//   head        : oldest destination
//   count       : number of valid entries (0..DEPTH)
//   full, empty : occupancy flags
// -----------------------------------------------------------------------------
module dist_sb_fifo
    import dist_pkg::*;
#(
    parameter int DEPTH = DIST_SB_DEPTH,
    parameter int CNT_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DREG_ADDR_W-1:0] push_data,
    input  logic                   pop,
    output logic [DREG_ADDR_W-1:0] head,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DREG_ADDR_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;

    // Entry storage and pointers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DREG_ADDR_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});

endmodule : dist_sb_fifo

// File: rtl/dist_writeback_scoreboard.sv
// -----------------------------------------------------------------------------
// dist_writeback_scoreboard
// Producer-side hazard tracker for distribution registers written by the
// multi-cycle distribution unit. Issued destinations are queued in order and
// marked pending; the unit's writeback retires the head. ID is stalled when it
// reads a register whose result is not yet produced (a same-cycle writeback
// is visible through the write-through register file, so it does not stall).
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   flush                   : pipeline flush, clears all in-flight state
//   issue_valid/issue_dest  : distribution op issued to the multi-cycle unit
//   issue_ready             : issue accepted (not full, no WAW hazard)
//   wb_valid/wb_dest        : writeback from the multi-cycle unit
//   id_src1/2, id_src1/2_used : ID-stage source operands
//   id_stall                : hold ID and the PC
//   pending_vec             : per-register in-flight flags
//   outstanding             : number of in-flight writes
//   wb_error                : sticky writeback protocol violation
// -----------------------------------------------------------------------------
module dist_writeback_scoreboard
    import dist_pkg::*;
#(
    parameter int DEPTH = DIST_SB_DEPTH,
    parameter int CNT_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   issue_valid,
    input  logic [DREG_ADDR_W-1:0] issue_dest,
    output logic                   issue_ready,
    input  logic                   wb_valid,
    input  logic [DREG_ADDR_W-1:0] wb_dest,
    input  logic [DREG_ADDR_W-1:0] id_src1,
    input  logic                   id_src1_used,
    input  logic [DREG_ADDR_W-1:0] id_src2,
    input  logic                   id_src2_used,
    output logic                   id_stall,
    output logic [DREG_NUM-1:0]    pending_vec,
    output logic [CNT_W-1:0]       outstanding,
    output logic                   wb_error
);

    logic [DREG_NUM-1:0]    pending_r;
    logic                   wb_error_r;
    logic [DREG_ADDR_W-1:0] head_s;
    logic [CNT_W-1:0]       count_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   wb_ok_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   waw_s;
    logic                   stall1_s;
    logic                   stall2_s;

    // A read or write of register a is covered if the writeback lands this cycle.
    function automatic logic wb_hit(input logic wv, input logic [DREG_ADDR_W-1:0] wd,
                                    input logic [DREG_ADDR_W-1:0] a);
        return wv && (wd == a);
    endfunction

    // Register a still waits for an unproduced result.
    function automatic logic busy(input logic [DREG_NUM-1:0] pend, input logic wv,
                                  input logic [DREG_ADDR_W-1:0] wd,
                                  input logic [DREG_ADDR_W-1:0] a);
        return (a != DREG_ZERO) && pend[a] && !wb_hit(wv, wd, a);
    endfunction

    // Hazard, acceptance and FIFO control decisions.
    always_comb begin
        waw_s    = busy(pending_r, wb_valid, wb_dest, issue_dest);
        stall1_s = id_src1_used && busy(pending_r, wb_valid, wb_dest, id_src1);
        stall2_s = id_src2_used && busy(pending_r, wb_valid, wb_dest, id_src2);
        // A writeback in the same cycle does not free a slot for this cycle's issue.
        issue_ready = !full_s && !waw_s;
        id_stall    = stall1_s || stall2_s;
        wb_ok_s     = wb_valid && !empty_s && (wb_dest == head_s);
        if (flush) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = issue_valid && issue_ready;
            pop_s  = wb_ok_s;
        end
    end

    dist_sb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push_s),
        .push_data (issue_dest),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Pending vector: clear on retire, then set on issue so a same-register set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {DREG_NUM{1'b0}};
        end else if (flush) begin
            pending_r <= {DREG_NUM{1'b0}};
        end else begin
            logic [DREG_NUM-1:0] nxt;
            nxt = pending_r;
            if (pop_s) begin
                nxt[wb_dest] = 1'b0;
            end
            if (push_s && (issue_dest != DREG_ZERO)) begin
                nxt[issue_dest] = 1'b1;
            end
            pending_r <= nxt;
        end
    end

    // Sticky protocol error: writeback with empty FIFO or not matching the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_error_r <= 1'b0;
        end else if (flush) begin
            wb_error_r <= wb_error_r;
        end else if (wb_valid && !wb_ok_s) begin
            wb_error_r <= 1'b1;
        end else begin
            wb_error_r <= wb_error_r;
        end
    end

    assign pending_vec = pending_r;
    assign outstanding = count_s;
    assign wb_error    = wb_error_r;

endmodule : dist_writeback_scoreboard

// File: tb/tb_dist_writeback_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_dist_writeback_scoreboard
// Directed self-checking bench for dist_writeback_scoreboard (DEPTH=4).
// -----------------------------------------------------------------------------
module tb_dist_writeback_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [4:0]  id_src1;
    logic        id_src1_used;
    logic [4:0]  id_src2;
    logic        id_src2_used;
    logic        id_stall;
    logic [31:0] pending_vec;
    logic [2:0]  outstanding;
    logic        wb_error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dist_writeback_scoreboard #(.DEPTH(4), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_dest      (wb_dest),
        .id_src1      (id_src1),
        .id_src1_used (id_src1_used),
        .id_src2      (id_src2),
        .id_src2_used (id_src2_used),
        .id_stall     (id_stall),
        .pending_vec  (pending_vec),
        .outstanding  (outstanding),
        .wb_error     (wb_error)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush        = 1'b0;
        issue_valid  = 1'b0;
        issue_dest   = 5'd0;
        wb_valid     = 1'b0;
        wb_dest      = 5'd0;
        id_src1      = 5'd0;
        id_src1_used = 1'b0;
        id_src2      = 5'd0;
        id_src2_used = 1'b0;
    endtask

    task automatic issue_one(input logic [4:0] d);
        issue_valid = 1'b1;
        issue_dest  = d;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic wb_one(input logic [4:0] d);
        wb_valid = 1'b1;
        wb_dest  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        // 1: reset state
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_pending", pending_vec, 32'h0000_0000);
        check("rst_outstanding", {29'd0, outstanding}, 32'd0);
        check("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        check("rst_id_stall", {31'd0, id_stall}, 32'd0);
        check("rst_wb_error", {31'd0, wb_error}, 32'd0);

        // 2: RAW stall and same-cycle writeback bypass
        issue_valid = 1'b1;
        issue_dest  = 5'd5;
        #1 check("t2_issue_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        issue_valid  = 1'b0;
        id_src1      = 5'd5;
        id_src1_used = 1'b1;
        #1;
        check("t2_stall", {31'd0, id_stall}, 32'd1);
        check("t2_pending", pending_vec, 32'h0000_0020);
        check("t2_outstanding", {29'd0, outstanding}, 32'd1);
        wb_valid = 1'b1;
        wb_dest  = 5'd5;
        #1 check("t2_stall_wb_same_cycle", {31'd0, id_stall}, 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("t2_pending_cleared", pending_vec, 32'h0000_0000);
        check("t2_outstanding_zero", {29'd0, outstanding}, 32'd0);
        check("t2_stall_after", {31'd0, id_stall}, 32'd0);
        idle_inputs();

        // 3: full FIFO, writeback does not free a slot in the same cycle
        issue_one(5'd1);
        issue_one(5'd2);
        issue_one(5'd3);
        issue_one(5'd4);
        check("t3_outstanding_full", {29'd0, outstanding}, 32'd4);
        check("t3_pending_full", pending_vec, 32'h0000_001E);
        issue_valid = 1'b1;
        issue_dest  = 5'd6;
        wb_valid    = 1'b1;
        wb_dest     = 5'd1;
        #1 check("t3_ready_full_with_wb", {31'd0, issue_ready}, 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("t3_outstanding_after_wb", {29'd0, outstanding}, 32'd3);
        check("t3_ready_next_cycle", {31'd0, issue_ready}, 32'd1);
        tick();
        issue_valid = 1'b0;
        #1;
        check("t3_outstanding_refill", {29'd0, outstanding}, 32'd4);
        check("t3_pending_refill", pending_vec, 32'h0000_005C);
        wb_one(5'd2);
        wb_one(5'd3);
        wb_one(5'd4);
        wb_one(5'd6);
        check("t3_drained", {29'd0, outstanding}, 32'd0);
        check("t3_no_error", {31'd0, wb_error}, 32'd0);

        // 4: WAW blocking and same-cycle retire/reissue of one register
        issue_one(5'd5);
        issue_valid = 1'b1;
        issue_dest  = 5'd5;
        #1 check("t4_waw_block", {31'd0, issue_ready}, 32'd0);
        tick();
        check("t4_not_accepted", {29'd0, outstanding}, 32'd1);
        wb_valid = 1'b1;
        wb_dest  = 5'd5;
        #1 check("t4_waw_with_wb", {31'd0, issue_ready}, 32'd1);
        tick();
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        #1;
        check("t4_pending_stays", pending_vec, 32'h0000_0020);
        check("t4_outstanding", {29'd0, outstanding}, 32'd1);
        wb_one(5'd5);
        check("t4_drained", {29'd0, outstanding}, 32'd0);

        // 5: register 0 and writeback protocol errors
        issue_one(5'd0);
        check("t5_pending_r0", pending_vec, 32'h0000_0000);
        check("t5_outstanding_r0", {29'd0, outstanding}, 32'd1);
        id_src1      = 5'd0;
        id_src1_used = 1'b1;
        #1 check("t5_no_stall_r0", {31'd0, id_stall}, 32'd0);
        id_src1_used = 1'b0;
        wb_one(5'd7);
        check("t5_wb_error", {31'd0, wb_error}, 32'd1);
        check("t5_no_pop_on_err", {29'd0, outstanding}, 32'd1);
        wb_one(5'd0);
        check("t5_pop_r0", {29'd0, outstanding}, 32'd0);
        check("t5_error_sticky", {31'd0, wb_error}, 32'd1);

        // 6: source 2 stall, flush priority, async reset
        issue_one(5'd2);
        issue_one(5'd3);
        issue_one(5'd9);
        check("t6_outstanding3", {29'd0, outstanding}, 32'd3);
        check("t6_pending3", pending_vec, 32'h0000_020C);
        id_src2      = 5'd9;
        id_src2_used = 1'b1;
        #1 check("t6_stall_src2", {31'd0, id_stall}, 32'd1);
        id_src2_used = 1'b0;
        #1 check("t6_src2_unused", {31'd0, id_stall}, 32'd0);
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_dest  = 5'd4;
        wb_valid    = 1'b1;
        wb_dest     = 5'd2;
        tick();
        idle_inputs();
        #1;
        check("t6_flush_outstanding", {29'd0, outstanding}, 32'd0);
        check("t6_flush_pending", pending_vec, 32'h0000_0000);
        check("t6_flush_ready", {31'd0, issue_ready}, 32'd1);
        check("t6_flush_holds_error", {31'd0, wb_error}, 32'd1);
        issue_one(5'd7);
        check("t6_pre_reset_pending", pending_vec, 32'h0000_0080);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_wb_error", {31'd0, wb_error}, 32'd0);
        check("t6_async_outstanding", {29'd0, outstanding}, 32'd0);
        check("t6_async_pending", pending_vec, 32'h0000_0000);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_dist_writeback_scoreboard

// File: doc/dist_writeback_scoreboard.md
Name: dist_writeback_scoreboard

Overview:
Producer-side hazard tracker for distribution registers. It records destinations issued to the multi-cycle distribution arithmetic unit and retires them on that unit's writeback. It raises an ID-stage stall when a distribution source read depends on a write still in flight. It complements the single-cycle EX/MEM distribution forwarding path, which cannot cover results that are not yet produced.

Parameters:
DEPTH, 4, maximum outstanding distribution writes (in-order completion FIFO entries); power of two, at least 2
CNT_W, 3, width of the outstanding count; equals log2(DEPTH)+1

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; the multi-cycle unit is flushed in the same cycle
issue_valid  in  1  ID issues a distribution op to the multi-cycle unit
issue_dest  in  5  destination distribution register of the issuing op
issue_ready  out  1  issue accepted this cycle if issue_valid is also high
wb_valid  in  1  multi-cycle unit writes a result this cycle
wb_dest  in  5  destination of that writeback
id_src1  in  5  ID distribution source 1 address
id_src1_used  in  1  source 1 is read by the ID instruction
id_src2  in  5  ID distribution source 2 address
id_src2_used  in  1  source 2 is read by the ID instruction
id_stall  out  1  hold ID and the PC this cycle
pending_vec  out  32  bit r is set while distribution register r has a write in flight
outstanding  out  CNT_W  number of FIFO entries
wb_error  out  1  sticky flag for a protocol violation on writeback

Behaviour:
- Reset (async, rst_n=0): FIFO empty, pending_vec=0, outstanding=0, wb_error=0. Consequently id_stall=0 and issue_ready=1.
- The design is clocked on the rising clk edge. issue_ready and id_stall are combinational from registered state and the current inputs.
- State: a FIFO of issued destinations (head = oldest), a 32-bit pending vector, and the count. Completion is strictly in order.
- Register 0 never has its pending bit set. An issue to register 0 still pushes a FIFO entry, because the unit still returns a writeback for it.
- wb_hit(a) = wb_valid && wb_dest==a.
- issue_ready = (outstanding<DEPTH) && !(issue_dest!=0 && pending_vec[issue_dest] && !wb_hit(issue_dest)). This blocks when the FIFO is full or on a WAW hazard.
- A full FIFO with a writeback in the same cycle still gives issue_ready=0. The freed slot becomes usable in the following cycle.
- id_stall = stall_src(1) || stall_src(2). stall_src(n) = id_srcn_used && id_srcn!=0 && pending_vec[id_srcn] && !wb_hit(id_srcn).
- Same-cycle writeback needs no stall: the distribution register file is write-through.
- A valid writeback has wb_valid, a non-empty FIFO, and wb_dest equal to the head. It pops the head and clears pending_vec[wb_dest].
- An invalid writeback (empty FIFO or a mismatch) sets wb_error. It causes no pop and no pending change.
- wb_error clears only on reset.
- An accepted issue pushes issue_dest and sets pending_vec[issue_dest] (when not 0).
- Issue and writeback in the same cycle are both applied, and outstanding stays unchanged. If both name the same register, the set wins and the bit stays 1.
- flush has priority: the FIFO is emptied and pending_vec and outstanding are cleared. A simultaneous issue or writeback is ignored, and wb_error is held.
- FIFO pointers wrap modulo DEPTH. outstanding never exceeds DEPTH and never goes below 0.

Decomposition:
- Shared package dist_pkg holds: DREG_ADDR_W=5, DREG_NUM=32, DREG_ZERO=5'd0, and the default DEPTH constant.
- One sub-module: dist_sb_fifo, a synchronous in-order FIFO with push, pop, head, count, full and empty, and flush/reset clear.
- Hazard and pending logic stay in the top module.

Test Plan:
1. Release reset with all inputs at 0 -> pending_vec=0, outstanding=0, issue_ready=1, id_stall=0, wb_error=0.
2. Issue dest 5; next cycle id_src1=5 with used=1 -> id_stall=1. In the wb_valid/wb_dest=5 cycle -> id_stall=0. Following cycle -> pending_vec[5]=0, outstanding=0.
3. Issue dests 1,2,3,4 -> outstanding=4, issue_ready=0. Writeback 1 in the same cycle as a held issue of 6 -> 6 not accepted. Next cycle -> 6 accepted, outstanding=4.
4. Issue 5; then issue 5 again -> issue_ready=0. Repeat with a same-cycle writeback of 5 -> accepted, pending_vec[5] stays 1, outstanding=1.
5. Issue 0 -> pending_vec=0, outstanding=1, id_src1=0 used gives no stall. Then writeback 7 with head 0 -> wb_error=1, outstanding=1. Writeback 0 -> outstanding=0, wb_error stays 1.
6. Three outstanding (2,3,9); flush together with issue 4 and writeback 2 -> next cycle outstanding=0, pending_vec=0, issue_ready=1. Then assert rst_n=0 mid-operation -> wb_error=0 immediately, without waiting for a clock edge.
